phoneme_player: RTL and testbench

//  Consumer end of the PicoBlaze phoneme_select output port. On a start strobe it looks up the

---
 rtl/phoneme_player_pkg.sv | 38 +++
 rtl/phoneme_span_rom.sv | 23 ++
 rtl/phoneme_player.sv | 140 ++++++++++++++
 tb/tb_phoneme_player.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phoneme_player_pkg.sv
// Shared types, span table contents and the sample-rate divisor helper for phoneme_player.
package phoneme_player_pkg;

    localparam int unsigned PHONEME_ADDR_W = 23;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FETCH,
        WAIT_DATA,
        PLAY_LO,
        PLAY_HI,
        DONE
    } state_t;

    typedef struct packed {
        logic [PHONEME_ADDR_W-1:0] start_word;
        logic [15:0]               length;
    } phoneme_entry_t;

    function automatic int unsigned sample_div(input int unsigned clk_hz,
                                               input int unsigned rate_hz);
        return clk_hz / rate_hz;
    endfunction

    // Span table: a few hand-placed phonemes, the rest one word each at code*256.
    function automatic phoneme_entry_t span_table(input logic [7:0] code);
        phoneme_entry_t e;
        case (code)
            8'd5:    begin e.start_word = 23'h000100; e.length = 16'd2; end
            8'd6:    begin e.start_word = 23'h000200; e.length = 16'd0; end
            8'd7:    begin e.start_word = 23'h7fffff; e.length = 16'd2; end
            default: begin e.start_word = {7'd0, code, 8'h00}; e.length = 16'd1; end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/phoneme_span_rom.sv
// Phoneme code to sample-span lookup; registered output, one cycle of latency.
module phoneme_span_rom
    import phoneme_player_pkg::*;
#(
    parameter int unsigned NUM_PHONEMES = 64,
    parameter int unsigned IDX_W        = $clog2(NUM_PHONEMES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] code,
    output phoneme_entry_t   entry
);

    phoneme_entry_t rom [NUM_PHONEMES];

    for (genvar i = 0; i < NUM_PHONEMES; i++) begin : g_rom
        assign rom[i] = span_table(8'(i));
    end

    always_ff @(posedge clk) begin
        entry <= rom[code];
    end

endmodule

// File: rtl/phoneme_player.sv
// Streams a phoneme's 32-bit sample words from memory as two signed 16-bit samples per word
// at the audio rate, pulsing done at the end so firmware can queue the next phoneme.
module phoneme_player
    import phoneme_player_pkg::*;
#(
    parameter int unsigned clk_freq_in_hz    = 25000000,
    parameter int unsigned sample_rate_in_hz = 22050,
    parameter int unsigned ADDR_W            = PHONEME_ADDR_W,
    parameter int unsigned NUM_PHONEMES      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        phoneme_select,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [15:0]       audio_sample,
    output logic              sample_valid
);

    localparam int unsigned SAMPLE_DIV = sample_div(clk_freq_in_hz, sample_rate_in_hz);
    localparam int unsigned CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned IDX_W      = $clog2(NUM_PHONEMES);

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [7:0]        code_q;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       words_left;
    logic [31:0]       word_q;
    logic              hi_sent;
    phoneme_entry_t    span;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Addressed straight from the port so the entry is ready during LOOKUP.
    phoneme_span_rom #(
        .NUM_PHONEMES (NUM_PHONEMES),
        .IDX_W        (IDX_W)
    ) u_span_rom (
        .clk   (clk),
        .code  (phoneme_select[IDX_W-1:0]),
        .entry (span)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            code_q       <= '0;
            addr         <= '0;
            words_left   <= '0;
            word_q       <= '0;
            hi_sent      <= 1'b0;
            mem_read     <= 1'b0;
            mem_addr     <= '0;
            audio_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        code_q <= phoneme_select;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if ({24'd0, code_q} >= NUM_PHONEMES || span.length == 16'd0) begin
                        state <= DONE;
                    end else begin
                        addr       <= ADDR_W'(span.start_word);
                        words_left <= span.length;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_read <= 1'b1;
                    mem_addr <= addr;
                    state    <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        word_q   <= mem_readdata;
                        mem_read <= 1'b0;
                        state    <= PLAY_LO;
                    end
                end
                PLAY_LO: begin
                    if (tick) begin
                        audio_sample <= word_q[15:0];
                        sample_valid <= 1'b1;
                        hi_sent      <= 1'b0;
                        state        <= PLAY_HI;
                    end
                end
                PLAY_HI: begin
                    // Advance one cycle after the hi sample so done trails its sample_valid.
                    if (hi_sent) begin
                        hi_sent <= 1'b0;
                        if (words_left == 16'd1) begin
                            state <= DONE;
                        end else begin
                            addr       <= addr + ADDR_W'(1);
                            words_left <= words_left - 16'd1;
                            state      <= FETCH;
                        end
                    end else if (tick) begin
                        audio_sample <= word_q[31:16];
                        sample_valid <= 1'b1;
                        hi_sent      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phoneme_player.sv
// Directed bench for phoneme_player with a sample/address scoreboard and a latency-configurable
// memory responder.
module tb_phoneme_player;

    localparam int DIV = 1133;

    typedef struct {
        logic [15:0] s;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  phoneme_select;
    logic        start;
    logic        busy;
    logic        done;
    logic [22:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_readdata = 32'd0;
    logic        mem_readdatavalid = 1'b0;
    logic [15:0] audio_sample;
    logic        sample_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_cnt = 0;
    int tsd = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_sv_cyc = 0;
    int rd_cycles = 0;
    int hold_drop = 0;
    int done_busy_bad = 0;
    int obs_n = 0;
    int obs_an = 0;
    int rd_i = 0;
    int ra_i = 0;
    int inj_req = 0;
    int inj_done = 0;
    int mem_cnt = 0;
    int mem_lat = 3;
    int st_cyc = 0;
    bit mem_en = 1'b1;
    bit mem_pending = 1'b0;
    logic [22:0] req_addr = '0;

    logic [15:0] obs_sample [64];
    int          obs_tsd    [64];
    logic [22:0] obs_addr   [32];

    exp_t        exp_s[$];
    logic [22:0] exp_a[$];

    phoneme_player dut (
        .clk               (clk),
        .reset             (reset),
        .phoneme_select    (phoneme_select),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .audio_sample      (audio_sample),
        .sample_valid      (sample_valid)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] tb_mem(input logic [22:0] a);
        if (a == 23'h100) return 32'hBBBB_AAAA;
        if (a == 23'h101) return 32'hDDDD_CCCC;
        return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'hC3C3};
    endfunction

    task automatic tb_span(input logic [7:0] code, output logic [22:0] sw, output logic [15:0] len);
        case (code)
            8'd5:    begin sw = 23'h100;    len = 16'd2; end
            8'd6:    begin sw = 23'h200;    len = 16'd0; end
            8'd7:    begin sw = 23'h7fffff; len = 16'd2; end
            default: begin sw = {7'd0, code, 8'h00}; len = 16'd1; end
        endcase
    endtask

    // Cycle count, reference tick counter, and ticks seen since the last data return.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) model_cnt <= 0;
        else model_cnt <= (model_cnt == DIV - 1) ? 0 : model_cnt + 1;
        if (mem_readdatavalid) tsd <= 0;
        else if (!reset && model_cnt == DIV - 1) tsd <= tsd + 1;
    end

    // Memory responder and output observers.
    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        if (mem_read) rd_cycles++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy_bad++;
        end
        if (sample_valid) begin
            obs_sample[obs_n % 64] = audio_sample;
            obs_tsd[obs_n % 64] = tsd;
            obs_n++;
            last_sv_cyc = cyc;
        end
        if (inj_req != inj_done) begin
            mem_readdata = 32'hDEAD_BEEF;
            mem_readdatavalid = 1'b1;
            inj_done = inj_req;
        end else begin
            if (!mem_pending && mem_en && mem_read) begin
                obs_addr[obs_an % 32] = mem_addr;
                obs_an++;
                req_addr = mem_addr;
                mem_pending = 1'b1;
                mem_cnt = mem_lat;
            end else if (mem_pending && !mem_read) begin
                hold_drop++;
                mem_pending = 1'b0;
            end
            if (mem_pending) begin
                if (mem_cnt == 0) begin
                    mem_readdata = tb_mem(req_addr);
                    mem_readdatavalid = 1'b1;
                    mem_pending = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_phoneme(input logic [7:0] code);
        logic [22:0] sw;
        logic [15:0] len;
        logic [22:0] a;
        logic [31:0] d;
        exp_t        e;
        tb_span(code, sw, len);
        if (code < 8'd64 && len != 16'd0) begin
            for (int w = 0; w < int'(len); w++) begin
                a = sw + 23'(w);
                exp_a.push_back(a);
                d = tb_mem(a);
                e.s = d[15:0];
                e.t = 1;
                exp_s.push_back(e);
                e.s = d[31:16];
                e.t = 2;
                exp_s.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] code);
        step();
        phoneme_select = code;
        start = 1'b1;
        st_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt, base + 1);
    endtask

    task automatic check_stream(input string tag);
        exp_t        e;
        logic [22:0] a;
        while (exp_s.size() > 0) begin
            e = exp_s.pop_front();
            if (rd_i < obs_n) begin
                chk({tag, "_sample"}, {16'd0, obs_sample[rd_i % 64]}, {16'd0, e.s});
                chk({tag, "_ticks_since_data"}, obs_tsd[rd_i % 64], e.t);
            end else begin
                chk({tag, "_sample_count"}, obs_n, rd_i + 1);
            end
            rd_i++;
        end
        chk({tag, "_no_extra_samples"}, obs_n, rd_i);
        rd_i = obs_n;
        while (exp_a.size() > 0) begin
            a = exp_a.pop_front();
            if (ra_i < obs_an) chk({tag, "_mem_addr"}, {9'd0, obs_addr[ra_i % 32]}, {9'd0, a});
            else chk({tag, "_read_count"}, obs_an, ra_i + 1);
            ra_i++;
        end
        chk({tag, "_no_extra_reads"}, obs_an, ra_i);
        ra_i = obs_an;
    endtask

    initial begin
        int base;
        int rd0;
        int sv0;
        int n;

        // Reset and idle
        reset = 1'b1;
        start = 1'b0;
        phoneme_select = 8'd0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_audio", audio_sample, 0);
        chk("rst_sample_valid", sample_valid, 0);
        rd0 = rd_cycles;
        repeat (100) step();
        chk("idle_no_read", rd_cycles, rd0);

        // Nominal playback of code 5
        mem_lat = 3;
        base = done_cnt;
        expect_phoneme(8'd5);
        pulse_start(8'd5);
        chk("nom_busy_after_start", busy, 1);
        wait_done(base, 8000, "nom");
        chk("nom_busy_at_done", busy, 0);
        chk("nom_done_latency", done_cyc, last_sv_cyc + 1);
        repeat (20) step();
        chk("nom_one_done", done_cnt, base + 1);
        chk("nom_busy_after", busy, 0);
        chk("nom_audio_held", audio_sample, 16'hDDDD);
        check_stream("nom");

        // Out-of-range code and zero-length entry
        rd0 = rd_cycles;
        base = done_cnt;
        pulse_start(8'h40);
        wait_done(base, 20, "inv");
        chk("inv_done_latency", done_cyc, st_cyc + 2);
        base = done_cnt;
        pulse_start(8'd6);
        wait_done(base, 20, "len0");
        chk("len0_done_latency", done_cyc, st_cyc + 2);
        repeat (5) step();
        chk("inv_no_read", rd_cycles, rd0);
        chk("inv_no_sample", obs_n, rd_i);

        // Slow memory: data returns long after the next tick
        mem_lat = 2000;
        rd0 = rd_cycles;
        base = done_cnt;
        expect_phoneme(8'd9);
        pulse_start(8'd9);
        wait_done(base, 10000, "slow");
        chk("slow_read_held", hold_drop, 0);
        chk("slow_read_cycles", rd_cycles - rd0 >= 2001, 1);
        check_stream("slow");

        // Start while busy, across the address wrap
        mem_lat = 3;
        base = done_cnt;
        expect_phoneme(8'd7);
        pulse_start(8'd7);
        repeat (1500) step();
        pulse_start(8'd5);
        wait_done(base, 8000, "busy");
        repeat (50) step();
        chk("busy_one_done", done_cnt, base + 1);
        check_stream("busy");

        // Reset while waiting for data, stray data afterwards
        mem_en = 1'b0;
        base = done_cnt;
        sv0 = obs_n;
        pulse_start(8'd5);
        n = 0;
        while (!mem_read && n < 10) begin
            step();
            n++;
        end
        chk("rstmid_read_issued", mem_read, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_read_dropped", mem_read, 0);
        inj_req++;
        step();
        step();
        chk("rstmid_no_read_2cyc", mem_read, 0);
        rd0 = rd_cycles;
        repeat (3000) step();
        chk("rstmid_no_done", done_cnt, base);
        chk("rstmid_no_sample", obs_n, sv0);
        chk("rstmid_idle", busy, 0);
        chk("rstmid_no_new_read", rd_cycles, rd0);
        mem_en = 1'b1;
        base = done_cnt;
        expect_phoneme(8'd5);
        pulse_start(8'd5);
        wait_done(base, 8000, "fresh");
        chk("fresh_done_latency", done_cyc, last_sv_cyc + 1);
        check_stream("fresh");
        chk("done_never_busy", done_busy_bad, 0);
        chk("read_never_dropped", hold_drop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
